// File: rtl/fetch_decode_queue.sv
// Bundle FIFO between the 4-wide fetch stage and decode.
// The oldest bundle falls through to decode; stall_fetch leaves room for bundles still in flight.
module fetch_decode_queue #(
    parameter int DEPTH        = 4,
    parameter int STALL_MARGIN = 1,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [63:0]      pc_in,
    input  logic [63:0]      inst_in,
    input  logic [63:0]      recv_pc_in,
    input  logic [3:0]       pred_in,
    input  logic             dec_ready,
    output logic             out_valid,
    output logic [63:0]      pc_out,
    output logic [63:0]      inst_out,
    output logic [63:0]      recv_pc_out,
    output logic [3:0]       pred_out,
    output logic             stall_fetch,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [63:0]      pc_mem_q   [DEPTH];
    logic [63:0]      inst_mem_q [DEPTH];
    logic [63:0]      recv_mem_q [DEPTH];
    logic [3:0]       pred_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic             full;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] wr_en;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && dec_ready && !flush;
    // A full queue still accepts a bundle when the head leaves in the same cycle.
    assign push      = in_valid && !flush && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (in_valid && full && !pop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = push && (wr_ptr_q == PTR_W'(gi));
    end

    // Flush leaves storage alone; only the pointers matter afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
                recv_mem_q[i] <= '0;
                pred_mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    pc_mem_q[i]   <= pc_in;
                    inst_mem_q[i] <= inst_in;
                    recv_mem_q[i] <= recv_pc_in;
                    pred_mem_q[i] <= pred_in;
                end
            end
        end
    end

    assign pc_out      = pc_mem_q[rd_ptr_q];
    assign inst_out    = inst_mem_q[rd_ptr_q];
    assign recv_pc_out = recv_mem_q[rd_ptr_q];
    assign pred_out    = pred_mem_q[rd_ptr_q];

    assign stall_fetch = (count_q >= CNT_W'(DEPTH - STALL_MARGIN));
    assign count       = count_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed plus randomized check of fetch_decode_queue against a queue-based model of the buffer.
module tb_fetch_decode_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] inst;
        logic [63:0] recv;
        logic [3:0]  pred;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [63:0] pc_in, inst_in, recv_pc_in;
    logic [3:0]  pred_in;
    logic        dec_ready;
    logic        out_valid;
    logic [63:0] pc_out, inst_out, recv_pc_out;
    logic [3:0]  pred_out;
    logic        stall_fetch;
    logic [2:0]  count;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    bundle_t mq[$];
    logic    m_ovf;
    bit      m_popped;
    logic [63:0] popped_pc;

    fetch_decode_queue #(.DEPTH(DEPTH), .STALL_MARGIN(1), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .pc_in(pc_in), .inst_in(inst_in), .recv_pc_in(recv_pc_in), .pred_in(pred_in),
        .dec_ready(dec_ready), .out_valid(out_valid), .pc_out(pc_out), .inst_out(inst_out),
        .recv_pc_out(recv_pc_out), .pred_out(pred_out), .stall_fetch(stall_fetch),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [63:0] inst,
                         input logic rdy, input logic fl);
        in_valid   = v;
        pc_in      = pc;
        inst_in    = inst;
        recv_pc_in = {$urandom, $urandom};
        pred_in    = 4'($urandom);
        dec_ready  = rdy;
        flush      = fl;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 64'(count), 64'(mq.size()));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        chk({tag, ".stall"}, 64'(stall_fetch), 64'(mq.size() >= DEPTH - 1));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        if (mq.size() != 0) begin
            chk({tag, ".pc"}, pc_out, mq[0].pc);
            chk({tag, ".inst"}, inst_out, mq[0].inst);
            chk({tag, ".recv"}, recv_pc_out, mq[0].recv);
            chk({tag, ".pred"}, 64'(pred_out), 64'(mq[0].pred));
        end
    endtask

    // One clock: model the edge from the current inputs, then compare just after it.
    task automatic step(input string tag);
        bundle_t b;
        bit pop, push, full;
        #2;
        b = '{pc: pc_in, inst: inst_in, recv: recv_pc_in, pred: pred_in};
        m_popped  = 0;
        popped_pc = pc_out;
        if (flush) begin
            mq.delete();
        end else begin
            full = (mq.size() == DEPTH);
            pop  = (mq.size() != 0) && dec_ready;
            push = in_valid && (!full || pop);
            if (in_valid && full && !pop) m_ovf = 1'b1;
            if (pop) begin
                void'(mq.pop_front());
                m_popped = 1;
            end
            if (push) mq.push_back(b);
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    initial begin
        int pushed;
        int next_exp;
        int cycles;

        // Reset with in_valid held high
        rst_n = 1'b0;
        drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
        mq.delete();
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.pc_out", pc_out, 64'd0);
        chk("rst.stall", 64'(stall_fetch), 64'd0);
        rst_n = 1'b1;

        // First bundle, then pop it
        drive(1'b1, 64'h0003_0002_0001_0000, {$urandom, $urandom}, 1'b0, 1'b0);
        step("first_push");
        chk("first_push.pc_lit", pc_out, 64'h0003_0002_0001_0000);
        drive(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
        step("first_pop");

        // Fill to four, stall appears at three
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
            step("fill");
        end
        chk("fill.count_lit", 64'(count), 64'd4);

        // Overflow attempt
        drive(1'b1, {$urandom, $urandom}, 64'hDEAD, 1'b0, 1'b0);
        step("ovf");
        chk("ovf.flag_lit", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
            step("drain");
        end

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
            step("refill");
        end
        drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
        step("full_pushpop");
        chk("full_pushpop.count_lit", 64'(count), 64'd4);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
            step("to_two");
        end

        // Flush with push and pop requested
        drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1);
        step("flush");
        chk("flush.count_lit", 64'(count), 64'd0);
        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        step("post_flush");

        // Asynchronous reset mid-cycle clears everything immediately
        drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
        step("pre_arst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.count", 64'(count), 64'd0);
        chk("arst.overflow", 64'(overflow), 64'd0);
        chk("arst.out_valid", 64'(out_valid), 64'd0);
        mq.delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sequential bundles, random decode back-pressure, fetch honouring the stall
        pushed   = 0;
        next_exp = 0;
        cycles   = 0;
        while ((pushed < 10 || mq.size() != 0) && cycles < 300) begin
            if (pushed < 10 && mq.size() < DEPTH - 1 && $urandom_range(0, 3) != 0) begin
                drive(1'b1, {48'($urandom), 16'(pushed * 4)}, {$urandom, $urandom},
                      1'($urandom), 1'b0);
                pushed++;
            end else begin
                drive(1'b0, {$urandom, $urandom}, 64'd0, 1'($urandom), 1'b0);
            end
            step("rand");
            if (m_popped) begin
                chk("rand.order", 64'(popped_pc[15:0]), 64'(next_exp));
                next_exp += 4;
            end
            cycles++;
        end
        chk("rand.all_seen", 64'(next_exp), 64'd40);
        chk("rand.no_ovf", 64'(overflow), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Bundle buffer between the 4-wide fetch stage and decode.
- Captures each fetch bundle (4 PCs, 4 instructions, 4 recovery PCs, 4 prediction bits) into a circular FIFO and presents the oldest bundle to decode with a valid/ready handshake.
- Generates stall_fetch back to fetch early enough to absorb the one-cycle fetch reaction latency.
- Flushes on misprediction recovery.

Parameters:
- DEPTH, 4, number of bundle entries; power of 2, minimum 2.
- STALL_MARGIN, 1, free entries reserved for in-flight fetch bundles when stall_fetch asserts.
- CNT_W, 3, width of count; must be at least log2(DEPTH)+1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  from ROB (has_mispredict); discards all entries.
- in_valid  input  1  fetch bundle valid this cycle.
- pc_in  input  64  four 16-bit PCs; slot0 in [15:0].
- inst_in  input  64  four 16-bit instructions; same slot order.
- recv_pc_in  input  64  four 16-bit recovery PCs.
- pred_in  input  4  per-slot branch prediction bits.
- dec_ready  input  1  decode accepts the head bundle this cycle.
- out_valid  output  1  head bundle valid.
- pc_out  output  64  head PCs.
- inst_out  output  64  head instructions.
- recv_pc_out  output  64  head recovery PCs.
- pred_out  output  4  head prediction bits.
- stall_fetch  output  1  high when count >= DEPTH-STALL_MARGIN.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- overflow  output  1  sticky error flag: push attempted while full with no pop.

Behaviour:
- Reset (asynchronous, any cycle, including mid-operation): wr_ptr=0, rd_ptr=0, count=0, overflow=0, all storage=0.
  - Consequently out_valid=0, stall_fetch=0, all data outputs=0.
- push = in_valid && !flush && (count<DEPTH || pop).
- pop = out_valid && dec_ready && !flush.
- out_valid = (count != 0). Data outputs are driven combinationally from the entry at rd_ptr (first-word-fall-through from registered storage).
- No bypass path: a bundle pushed at edge N is visible on the outputs after edge N; earliest pop is at edge N+1. Latency through an empty queue is 1 cycle.
- Push writes all four fields to entry wr_ptr; wr_ptr increments modulo DEPTH.
- Pop increments rd_ptr modulo DEPTH. Wrap-around is natural pointer rollover.
- Occupancy update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop: count unchanged.
  - Push and pop are allowed together when full or empty-with-pop-impossible; when empty, pop is 0.
- Full with simultaneous pop: the push is accepted and count stays at DEPTH.
- Full without pop and in_valid=1:
  - bundle dropped; storage and pointers unchanged; overflow set to 1 at the edge.
  - overflow is cleared only by reset, not by flush.
- stall_fetch is combinational from count.
  - DEPTH=4, STALL_MARGIN=1: asserts at count>=3.
  - With fetch honouring the stall one cycle later, no overflow occurs.
- Flush (synchronous, highest priority):
  - At the edge: count=0, wr_ptr=0, rd_ptr=0. Any same-cycle push and pop are ignored. Storage contents need not be cleared.
  - The cycle after flush: out_valid=0, stall_fetch=0.
- dec_ready while out_valid=0: no effect.
- Ordering: bundles exit in exactly the order accepted. Fields of one bundle never mix with fields of another.

Test Plan:
- Reset with in_valid=1 held, then release: out_valid=0 and count=0 during reset. Push pc_in=0x0003_0002_0001_0000 at edge 1 -> out_valid=1 and pc_out=0x0003_0002_0001_0000 after edge 1; dec_ready=1 -> count returns to 0 after edge 2.
- Push 3 bundles with dec_ready=0 -> stall_fetch=1 after the 3rd edge. Push a 4th -> count=4, overflow=0.
- At count=4, dec_ready=0, push inst_in=0xDEAD -> overflow=1, count=4, head unchanged. Then pop 4 -> original order intact, overflow remains 1.
- At count=4, in_valid=1 and dec_ready=1 together -> count stays 4, head advances, new bundle lands at the tail.
- At count=2, assert flush with in_valid=1 and dec_ready=1 -> after the edge count=0, out_valid=0, stall_fetch=0. The pushed bundle is absent.
- Push 10 sequential bundles (pc slot0 = 0,4,8,...,36) with random dec_ready and pop -> decode sees exactly 0..36 in order across pointer wrap, and no overflow.
